// File: rtl/ldpc_pkg.sv
// Shared types and sizing helpers for the LDPC decoder front-end scheduler.
// Header word layout: [7:0] rows, [15:8] cols, [23:16] iterations, [31:24] block size.
package ldpc_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CONF_HDR,
        S_CONF_GAP,
        S_CONF_BODY,
        S_FR_START,
        S_FR_GAP,
        S_FR_DATA,
        S_WAIT_DONE,
        S_DRAIN
    } sched_state_t;

    localparam int unsigned HDR_ROWS_LSB  = 0;
    localparam int unsigned HDR_COLS_LSB  = 8;
    localparam int unsigned HDR_ITERS_LSB = 16;
    localparam int unsigned HDR_BLK_LSB   = 24;

    // Decoder words needed to carry the full H-matrix body.
    function automatic int unsigned conf_words(input int unsigned rows, input int unsigned cols,
                                               input int unsigned wb, input int unsigned w);
        return (rows * cols * wb + w - 1) / w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ldpc_rr_arbiter.sv
// Round-robin grant among requesters, searching upward from a stored pointer.
module ldpc_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr_load,
    input  logic [ID_W-1:0]    ptr_val,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);

    logic [ID_W-1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (ptr_load)
            ptr <= ptr_val;
    end

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ldpc_frame_scheduler.sv
// Loads H-matrix configuration into the shared ldpc_decoder and time-shares it between requesters per frame.
// Optional WAIT_DONE watchdog: define LDPC_SCHED_TIMEOUT_EN.
module ldpc_frame_scheduler
    import ldpc_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned MAX_BLOCK_SIZE = 64,
    parameter int unsigned MAX_ROWS       = 18,
    parameter int unsigned MAX_COLS       = 32,
    parameter int unsigned WIDTH_BLOCK    = 6,
    parameter int unsigned TIMEOUT_CYC    = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    input  logic [MAX_BLOCK_SIZE-1:0]     cfg_data,
    output logic                          cfg_ready,
    output logic                          cfg_err,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*MAX_BLOCK_SIZE-1:0] in_data,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          dec_start_conf,
    output logic                          dec_start,
    output logic [MAX_BLOCK_SIZE-1:0]     dec_data_in,
    input  logic [MAX_BLOCK_SIZE-1:0]     dec_data_out,
    input  logic                          dec_valid,
    input  logic                          dec_done,
    output logic                          out_valid,
    output logic [MAX_BLOCK_SIZE-1:0]     out_data,
    output logic                          out_last,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    output logic [1:0]                    out_status
);

    localparam int unsigned CONF_WORDS = conf_words(MAX_ROWS, MAX_COLS, WIDTH_BLOCK, MAX_BLOCK_SIZE);
    localparam int unsigned CNT_W      = cnt_width(CONF_WORDS, MAX_COLS);
    localparam int unsigned ID_W       = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONF_WORDS - 1);
    localparam logic [CNT_W-1:0] COLS_LAST = CNT_W'(MAX_COLS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(1);

    sched_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0] id;
    logic            frame_err;
    logic            dec_ok;
    logic            config_loaded;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic            ptr_load;
    logic [ID_W-1:0] ptr_val;

`ifdef LDPC_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt;
    logic            timed_out;
`endif

    assign ptr_load = (state == S_DRAIN) && (cnt == COLS_LAST);
    assign ptr_val  = (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);

    ldpc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .ptr_load  (ptr_load),
        .ptr_val   (ptr_val),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            id            <= '0;
            frame_err     <= 1'b0;
            dec_ok        <= 1'b0;
            cfg_err       <= 1'b0;
            config_loaded <= 1'b0;
`ifdef LDPC_SCHED_TIMEOUT_EN
            to_cnt        <= '0;
            timed_out     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (cfg_valid)
                        state <= S_CONF_HDR;
                    else if (config_loaded && gnt_valid) begin
                        id        <= gnt_id;
                        frame_err <= 1'b0;
                        dec_ok    <= 1'b0;
                        state     <= S_FR_START;
                    end
                end
                S_CONF_HDR: begin
                    cfg_err <= 1'b0;
                    state   <= S_CONF_GAP;
                end
                S_CONF_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= S_CONF_BODY;
                    end else
                        cnt <= cnt + 1'b1;
                end
                S_CONF_BODY: begin
                    if (!cfg_valid)
                        cfg_err <= 1'b1;
                    if (cnt == CONF_LAST) begin
                        cnt           <= '0;
                        config_loaded <= 1'b1;
                        state         <= S_IDLE;
                    end else
                        cnt <= cnt + 1'b1;
                end
                S_FR_START: state <= S_FR_GAP;
                S_FR_GAP:   state <= S_FR_DATA;
                S_FR_DATA: begin
                    if (!in_valid[id])
                        frame_err <= 1'b1;
                    if (cnt == COLS_LAST) begin
                        cnt   <= '0;
                        state <= S_WAIT_DONE;
                    end else
                        cnt <= cnt + 1'b1;
                end
                S_WAIT_DONE: begin
                    if (dec_done) begin
                        dec_ok <= dec_valid;
                        state  <= S_DRAIN;
`ifdef LDPC_SCHED_TIMEOUT_EN
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt    <= '0;
                        timed_out <= 1'b1;
                        frame_err <= 1'b1;
                        dec_ok    <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                S_DRAIN: begin
                    if (cnt == COLS_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
`ifdef LDPC_SCHED_TIMEOUT_EN
                        timed_out <= 1'b0;
`endif
                    end else
                        cnt <= cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshakes and decoder data are decoded from the registered state so they align with the word being moved.
    always_comb begin
        cfg_ready      = 1'b0;
        in_ready       = '0;
        dec_start_conf = 1'b0;
        dec_start      = 1'b0;
        dec_data_in    = '0;
        out_valid      = 1'b0;
        out_data       = '0;
        out_last       = 1'b0;
        out_id         = '0;
        out_status     = 2'b00;
        case (state)
            S_CONF_HDR: begin
                cfg_ready      = 1'b1;
                dec_start_conf = 1'b1;
                dec_data_in    = cfg_data;
            end
            S_CONF_BODY: begin
                cfg_ready      = 1'b1;
                dec_start_conf = (cnt == CONF_LAST);
                dec_data_in    = cfg_valid ? cfg_data : '0;
            end
            S_FR_START: dec_start = 1'b1;
            S_FR_DATA: begin
                in_ready    = NUM_REQ'(1) << id;
                dec_data_in = in_valid[id] ? in_data[32'(id)*MAX_BLOCK_SIZE +: MAX_BLOCK_SIZE] : '0;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
`ifdef LDPC_SCHED_TIMEOUT_EN
                out_data  = timed_out ? '0 : dec_data_out;
`else
                out_data  = dec_data_out;
`endif
                out_id    = id;
                if (cnt == COLS_LAST) begin
                    out_last   = 1'b1;
                    out_status = {frame_err, dec_ok};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldpc_frame_scheduler.sv
// Randomized self-checking bench for ldpc_frame_scheduler; the bench also plays the decoder.
// Define LDPC_SCHED_TIMEOUT_EN to exercise the WAIT_DONE watchdog.
module tb_ldpc_frame_scheduler;

    localparam int W        = 64;
    localparam int NR       = 2;
    localparam int COLS     = 32;
    localparam int CWORDS   = (18 * 32 * 6 + W - 1) / W;
    localparam int TIMEOUT  = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid;
    logic [W-1:0]    cfg_data;
    logic            cfg_ready;
    logic            cfg_err;
    logic [NR-1:0]   in_valid;
    logic [NR*W-1:0] in_data;
    logic [NR-1:0]   in_ready;
    logic            dec_start_conf;
    logic            dec_start;
    logic [W-1:0]    dec_data_in;
    logic [W-1:0]    dec_data_out;
    logic            dec_valid;
    logic            dec_done;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic            out_id;
    logic [1:0]      out_status;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ptr = 0;

    ldpc_frame_scheduler #(
        .NUM_REQ        (NR),
        .MAX_BLOCK_SIZE (W),
        .MAX_ROWS       (18),
        .MAX_COLS       (COLS),
        .WIDTH_BLOCK    (6),
        .TIMEOUT_CYC    (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_data       (cfg_data),
        .cfg_ready      (cfg_ready),
        .cfg_err        (cfg_err),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .dec_start_conf (dec_start_conf),
        .dec_start      (dec_start),
        .dec_data_in    (dec_data_in),
        .dec_data_out   (dec_data_out),
        .dec_valid      (dec_valid),
        .dec_done       (dec_done),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_id         (out_id),
        .out_status     (out_status)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    function automatic int pick_req(input logic [NR-1:0] mask);
        for (int k = 0; k < NR; k++)
            if (mask[(exp_ptr + k) % NR]) return (exp_ptr + k) % NR;
        return -1;
    endfunction

    task automatic load_config(input int underrun_idx);
        logic [W-1:0] hdr;
        logic [W-1:0] body [CWORDS];
        logic [W-1:0] exp_w;
        int t;
        hdr = 64'h0000_0000_0632_2012;
        foreach (body[i]) body[i] = rnd_word();
        t = -1;
        for (int g = 0; g < 8 && t < 0; g++) begin
            @(negedge clk);
            in_valid  = '0;
            cfg_valid = 1'b1;
            cfg_data  = hdr;
            #1;
            if (cfg_ready) t = 0;
        end
        if (t < 0) begin
            check_eq("cfg_hdr_wait", 0, 1);
            return;
        end
        check_eq("conf_hdr", {cfg_ready, dec_start_conf, dec_data_in}, {1'b1, 1'b1, hdr});
        for (t = 1; t <= CWORDS + 2; t++) begin
            @(negedge clk);
            if (t < 3) begin
                cfg_valid = 1'b1;
                cfg_data  = body[0];
                exp_w     = '0;
            end else if (t - 3 == underrun_idx) begin
                cfg_valid = 1'b0;
                cfg_data  = rnd_word();
                exp_w     = '0;
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = body[t-3];
                exp_w     = body[t-3];
            end
            #1;
            if (t == 1)
                check_eq("conf_err_clear", cfg_err, 0);
            check_eq($sformatf("conf_%0d", t), {cfg_ready, dec_start_conf, dec_data_in},
                     {(t >= 3), (t == CWORDS + 2), exp_w});
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check_eq("conf_end", {cfg_ready, dec_start_conf, cfg_err}, {1'b0, 1'b0, (underrun_idx >= 0)});
    endtask

    task automatic wait_start(input logic [NR-1:0] mask, output bit found);
        found = 1'b0;
        for (int g = 0; g < 8 && !found; g++) begin
            @(negedge clk);
            in_valid = mask;
            in_data  = {rnd_word(), rnd_word()};
            dec_done = 1'b0;
            #1;
            if (dec_start) found = 1'b1;
        end
        check_eq("fr_start_seen", found, 1);
    endtask

    // done_delay < 0: decoder never answers (watchdog build only).
    task automatic do_frame(input logic [NR-1:0] mask, input int drop, input int done_delay, input bit dv);
        int eid;
        bit found;
        bit exp_err;
        bit to_hit;
        bit pre;
        logic [W-1:0] w;
        eid = pick_req(mask);
        wait_start(mask, found);
        if (!found) return;
        check_eq("fr_start", {in_ready, dec_data_in}, 0);
        @(negedge clk);
        in_data = {rnd_word(), rnd_word()};
        #1;
        check_eq("fr_gap", {dec_start, in_ready, dec_data_in}, 0);
        exp_err = 1'b0;
        for (int j = 0; j < COLS; j++) begin
            @(negedge clk);
            in_data  = {rnd_word(), rnd_word()};
            in_valid = mask;
            if (j == drop) begin
                in_valid[eid] = 1'b0;
                exp_err       = 1'b1;
            end
            dec_done  = (j == 10);
            dec_valid = 1'($urandom);
            #1;
            w = (j == drop) ? '0 : in_data[eid*W +: W];
            check_eq($sformatf("fr_word_%0d", j), {in_ready, dec_data_in}, {NR'(1) << eid, w});
        end
        to_hit = 1'b0;
        pre    = 1'b0;
        if (done_delay >= 0) begin
            for (int k = 0; k < done_delay; k++) begin
                @(negedge clk);
                in_valid = mask;
                dec_done = 1'b0;
                #1;
                check_eq("wait_idle", {in_ready, dec_data_in, out_valid, dec_start}, 0);
            end
            @(negedge clk);
            dec_done  = 1'b1;
            dec_valid = dv;
            #1;
            check_eq("wait_done_cyc", {in_ready, dec_data_in, out_valid}, 0);
        end else begin
`ifdef LDPC_SCHED_TIMEOUT_EN
            for (int k = 0; k < TIMEOUT + 16 && !pre; k++) begin
                @(negedge clk);
                dec_done     = 1'b0;
                dec_data_out = rnd_word();
                #1;
                if (out_valid) pre = 1'b1;
            end
            check_eq("timeout_seen", pre, 1);
            to_hit  = 1'b1;
            exp_err = 1'b1;
`endif
        end
        for (int j = 0; j < COLS; j++) begin
            if (!(j == 0 && pre)) begin
                @(negedge clk);
                dec_done     = 1'($urandom);
                dec_valid    = 1'($urandom);
                dec_data_out = rnd_word();
                #1;
            end
            check_eq($sformatf("drain_%0d", j), {out_valid, out_data, out_id, out_last, out_status},
                     {1'b1, to_hit ? 64'd0 : dec_data_out, 1'(eid), (j == COLS - 1),
                      (j == COLS - 1) ? {exp_err, dv & ~to_hit} : 2'b00});
        end
        dec_done = 1'b0;
        exp_ptr  = (eid + 1) % NR;
    endtask

    initial begin
        int busy;
        bit found;
        logic [NR-1:0] m;
        rst          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_data     = '0;
        in_valid     = '0;
        in_data      = '0;
        dec_data_out = '0;
        dec_valid    = 1'b0;
        dec_done     = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_a", {cfg_ready, cfg_err, in_ready, dec_start_conf, dec_start, dec_data_in}, 0);
        check_eq("reset_b", {out_valid, out_data, out_last, out_id, out_status}, 0);
        rst = 1'b0;

        // No grant before configuration.
        busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 2'b01;
            in_data  = {rnd_word(), rnd_word()};
            #1;
            if (dec_start || in_ready != 0) busy++;
        end
        check_eq("no_grant_unconfigured", busy, 0);

        load_config(-1);
        do_frame(2'b01, -1, 3, 1'b1);

        // Continuous contention: alternating grants.
        for (int f = 0; f < 4; f++)
            do_frame(2'b11, -1, $urandom_range(0, 5), 1'($urandom));

        m = 2'b10;
        do_frame(m, 5, 2, 1'b1);

        for (int f = 0; f < 4; f++) begin
            m = 2'($urandom_range(1, 3));
            do_frame(m, ($urandom_range(0, 1) == 1) ? $urandom_range(0, COLS - 1) : -1,
                     $urandom_range(0, 6), 1'($urandom));
        end

        load_config(7);
        load_config(-1);
        do_frame(2'b11, -1, 200, 1'b0);
`ifdef LDPC_SCHED_TIMEOUT_EN
        do_frame(2'b11, -1, -1, 1'b0);
`endif

        // Reset while forwarding frame data.
        wait_start(2'b01, found);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            in_data = {rnd_word(), rnd_word()};
        end
        #1;
        check_eq("pre_rst_data", in_ready, 2'b01);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_a", {cfg_ready, cfg_err, in_ready, dec_start_conf, dec_start, dec_data_in}, 0);
        check_eq("rst_mid_b", {out_valid, out_data, out_last, out_id, out_status}, 0);
        @(negedge clk);
        rst     = 1'b0;
        exp_ptr = 0;
        busy    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 2'b11;
            #1;
            if (dec_start || in_ready != 0 || out_valid) busy++;
        end
        check_eq("no_grant_after_rst", busy, 0);
        load_config(-1);
        do_frame(2'b11, -1, 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
